random_bank: RTL and testbench
==============================

Name: random_bank

Overview:
- Parametrised multi-channel Galois-LFSR random source. Successor to the single 32-bit seedable generator.
- Runs entirely on the system clock; an internal tick divider replaces the derived slow clock.
- Provides per-channel derived seeds, three advance modes, and a valid/ready output handshake with a drop counter.
- Feeds ant-simulation randomness (direction, pheromone noise) and the board-level random display harness.

Parameters:
- WIDTH, 32, bits per channel.
- CHANNELS, 4, number of independent LFSR channels.
- TAPS, 32'hA3000000, Galois feedback mask (WIDTH bits).
- DIVIDE, 25000000, clk cycles per advance in tick mode (≥1).
- STRIDE, 32'h9E3779B9, per-channel seed offset.
- DEFAULT_SEED, 32'd1907200704, seed applied at reset.

Ports:
- clk  in  1  system clock.
- RESET_SIM  in  1  asynchronous active-high reset.
- ld_seed  in  1  load derived seeds from seed this cycle.
- seed  in  WIDTH  base seed.
- mode  in  2  0 hold, 1 free-run, 2 tick, 3 step.
- step  in  1  advance request (mode 3 only), sampled per cycle.
- out_ready  in  1  consumer accepts value.
- out_valid  out  1  value holds an unconsumed word.
- value  out  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- drops  out  16  saturating count of advances not captured.

Behaviour:
- Seed derivation:
  - s_i = seed ^ (i*STRIDE), truncated to WIDTH.
  - If s_i == 0, use 1 instead; an LFSR state is never zero.
- LFSR step per channel: next = (x>>1) ^ (x[0] ? TAPS : 0).
- Reset (async):
  - lfsr[i] = derived(DEFAULT_SEED, i).
  - value = 0, out_valid = 0, drops = 0, divider = 0.
- Divider:
  - Counts 0..DIVIDE-1 only while mode==2; div_wrap when count==DIVIDE-1, then returns to 0.
  - Forced to 0 when mode!=2 or on ld_seed.
- Advance event adv:
  - mode0: 0.
  - mode1: 1 every cycle.
  - mode2: div_wrap.
  - mode3: step.
- Priority per cycle: ld_seed > adv.
  - ld_seed: load all derived seeds; clear out_valid; clear drops; no advance this cycle even if adv.
- On adv:
  - All channels step together.
  - If !out_valid || out_ready: value <= stepped states, out_valid <= 1 (latency one edge).
  - Else: value holds, drops <= drops+1, saturating at 16'hFFFF; the LFSRs still advance.
- No adv, out_valid && out_ready: out_valid <= 0 at the edge.
- adv with out_ready=1 while valid: consume and capture in the same edge; out_valid stays 1.
- Mode change takes effect the same cycle; switching away from mode 2 discards the partial divider count.
- Reset mid-operation returns immediately to reset values regardless of handshake state.

Test Plan:
1. CHANNELS=2, ld_seed seed=1, mode=3, one step pulse, out_ready=1 -> next edge out_valid=1, ch0=0xA3000000, ch1=0x4F1BBCDC.
2. Continue from 1, second step -> ch0=0x51800000; with no adv and out_ready=1, out_valid falls the following edge.
3. ld_seed seed=0, one step -> ch0=0xA3000000 (zero guarded to 1), ch1=0xEC1BBCDC.
4. DIVIDE=4, mode=2, out_ready=1 held -> out_valid single-cycle pulses every 4 cycles, value changes only on those edges; switching to mode 0 for 2 cycles and back restarts the 4-cycle count.
5. mode=1, out_ready=0 for 10 cycles from empty -> first adv captures, value frozen, drops=9; then out_ready=1 -> consume with recapture each cycle, drops stays 9.
6. ld_seed and step together -> seeds loaded, no advance, out_valid=0, drops=0; assert RESET_SIM mid tick count -> all outputs 0 immediately, state = DEFAULT_SEED derivation.

Source files
------------

// File: rtl/random_bank.sv
// random_bank: multi-channel Galois-LFSR random source with a per-channel
// derived seed, hold/free-run/tick/step advance modes and a valid/ready
// output register that counts advances the consumer failed to pick up.

// One LFSR channel: holds its state and exposes the next (stepped) state.
module random_bank_lane #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] TAPS      = 32'hA3000000,
   parameter logic [WIDTH-1:0] RST_STATE = 32'd1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             adv,
   input  logic [WIDTH-1:0] ld_state,
   output logic [WIDTH-1:0] stepped
);

   logic [WIDTH-1:0] state;

   assign stepped = (state >> 1) ^ (state[0] ? TAPS : '0);

   // Seed load wins over advance; otherwise the state only moves on adv.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state <= RST_STATE;
      else if (ld)  state <= ld_state;
      else if (adv) state <= stepped;
   end

endmodule

// Top: channel array, tick divider, advance selection and output handshake.
module random_bank #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      CHANNELS     = 4,
   parameter logic [WIDTH-1:0] TAPS         = 32'hA3000000,
   parameter int unsigned      DIVIDE       = 25000000,
   parameter logic [WIDTH-1:0] STRIDE       = 32'h9E3779B9,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'd1907200704
) (
   input  logic                      clk,
   input  logic                      RESET_SIM,
   input  logic                      ld_seed,
   input  logic [WIDTH-1:0]          seed,
   input  logic [1:0]                mode,
   input  logic                      step,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [CHANNELS*WIDTH-1:0] value,
   output logic [15:0]               drops
);

   localparam int unsigned DW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

   typedef enum logic [1:0] {
      M_HOLD = 2'd0,
      M_FREE = 2'd1,
      M_TICK = 2'd2,
      M_STEP = 2'd3
   } mode_t;

   mode_t                            mode_e;
   logic [DW-1:0]                    div_cnt;
   logic                             div_wrap;
   logic                             adv;
   logic [CHANNELS-1:0][WIDTH-1:0]   stepped;
   logic [CHANNELS-1:0][WIDTH-1:0]   val_q;

   assign mode_e   = mode_t'(mode);
   assign div_wrap = (mode_e == M_TICK) && (div_cnt == DW'(DIVIDE - 1));
   assign value    = val_q;

   // Tick divider: only runs in tick mode, any other mode or a seed load
   // throws away the partial count so the next period starts fresh.
   always_ff @(posedge clk or posedge RESET_SIM) begin
      if (RESET_SIM)                                     div_cnt <= '0;
      else if (ld_seed || mode_e != M_TICK || div_wrap)  div_cnt <= '0;
      else                                               div_cnt <= div_cnt + 1'b1;
   end

   // Advance event selected by mode.
   always_comb begin
      adv = 1'b0;
      case (mode_e)
         M_HOLD:  adv = 1'b0;
         M_FREE:  adv = 1'b1;
         M_TICK:  adv = div_wrap;
         M_STEP:  adv = step;
         default: adv = 1'b0;
      endcase
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      // Per-channel seed offset; a zero seed would lock the LFSR, so it
      // is replaced with 1 both at reset and on a runtime load.
      localparam logic [WIDTH-1:0] OFS     = STRIDE * WIDTH'(i);
      localparam logic [WIDTH-1:0] RST_RAW = DEFAULT_SEED ^ OFS;
      localparam logic [WIDTH-1:0] RST_S   = (RST_RAW == '0) ? WIDTH'(1) : RST_RAW;

      logic [WIDTH-1:0] raw;
      logic [WIDTH-1:0] ld_s;

      assign raw  = seed ^ OFS;
      assign ld_s = (raw == '0) ? WIDTH'(1) : raw;

      random_bank_lane #(
         .WIDTH     (WIDTH),
         .TAPS      (TAPS),
         .RST_STATE (RST_S)
      ) u_lane (
         .clk      (clk),
         .rst      (RESET_SIM),
         .ld       (ld_seed),
         .adv      (adv && !ld_seed),
         .ld_state (ld_s),
         .stepped  (stepped[i])
      );
   end

   // Output register: capture on advance when the slot is free or being
   // consumed this edge, otherwise count the lost word (saturating).
   always_ff @(posedge clk or posedge RESET_SIM) begin
      if (RESET_SIM) begin
         val_q     <= '0;
         out_valid <= 1'b0;
         drops     <= 16'd0;
      end else if (ld_seed) begin
         out_valid <= 1'b0;
         drops     <= 16'd0;
      end else if (adv) begin
         if (!out_valid || out_ready) begin
            val_q     <= stepped;
            out_valid <= 1'b1;
         end else if (drops != 16'hFFFF) begin
            drops <= drops + 16'd1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_random_bank.sv
// Scoreboard bench for random_bank (2 channels, divide-by-4 tick).
// Stimulus pushes hand-computed words; a monitor pops one per handshake.
module tb_random_bank;

   logic        clk = 1'b0;
   logic        RESET_SIM;
   logic        ld_seed;
   logic [31:0] seed;
   logic [1:0]  mode;
   logic        step;
   logic        out_ready;
   logic        out_valid;
   logic [63:0] value;
   logic [15:0] drops;

   logic        mon_en;
   logic [63:0] expq[$];
   int          tests = 0;
   int          fails = 0;

   localparam logic [63:0] W_S1A  = {32'h4F1BBCDC, 32'hA3000000};
   localparam logic [63:0] W_S1B  = {32'h278DDE6E, 32'h51800000};
   localparam logic [63:0] W_S0A  = {32'hEC1BBCDC, 32'hA3000000};
   localparam logic [63:0] W_A    = {32'h760DDE6E, 32'h51800000};
   localparam logic [63:0] W_B    = {32'h3B06EF37, 32'h28C00000};
   localparam logic [63:0] W_C    = {32'hBE83779B, 32'h14600000};
   localparam logic [63:0] W_D    = {32'hFC41BBCD, 32'h0A300000};
   localparam logic [63:0] W_RST  = {32'hD4CD75BC, 32'h38D6C960};

   random_bank #(
      .WIDTH    (32),
      .CHANNELS (2),
      .DIVIDE   (4)
   ) dut (
      .clk       (clk),
      .RESET_SIM (RESET_SIM),
      .ld_seed   (ld_seed),
      .seed      (seed),
      .mode      (mode),
      .step      (step),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .value     (value),
      .drops     (drops)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one word leaves the DUT on every edge with valid && ready.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && !RESET_SIM && out_valid && out_ready) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_unexpected: got %h expected none", value);
            end else begin
               e = expq.pop_front();
               check("sb_value", value, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_SIM = 1'b1; ld_seed = 1'b0; seed = '0; mode = 2'd0;
      step = 1'b0; out_ready = 1'b0; mon_en = 1'b1;
      @(negedge clk);
      check("rst_value", value, 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_drops", 64'(drops), 64'd0);
      tick();
      RESET_SIM = 1'b0;

      // 1: seed=1, single step
      ld_seed = 1'b1; seed = 32'd1; mode = 2'd3; out_ready = 1'b1;
      tick();
      ld_seed = 1'b0; step = 1'b1; expq.push_back(W_S1A);
      tick();
      step = 1'b0;
      tick();

      // 2: second step, then valid falls with no advance
      step = 1'b1; expq.push_back(W_S1B);
      tick();
      step = 1'b0;
      @(negedge clk);
      check("t2_valid_hi", 64'(out_valid), 64'd1);
      tick();
      @(negedge clk);
      check("t2_valid_fall", 64'(out_valid), 64'd0);

      // 3: zero seed guarded to 1 on channel 0
      ld_seed = 1'b1; seed = 32'd0;
      tick();
      ld_seed = 1'b0; step = 1'b1; expq.push_back(W_S0A);
      tick();
      step = 1'b0;
      tick();
      tick();

      // 4: tick mode, pulses every 4 edges; mode 0 discards partial count
      mode = 2'd2;
      expq.push_back(W_A); expq.push_back(W_B); expq.push_back(W_C);
      for (int k = 1; k <= 10; k++) begin
         tick();
         @(negedge clk);
         check($sformatf("t4_pulse_%0d", k), 64'(out_valid), 64'((k % 4) == 0));
         if (k == 6) check("t4_value_held", value, W_A);
      end
      mode = 2'd0;
      for (int k = 1; k <= 2; k++) begin
         tick();
         @(negedge clk);
         check("t4_hold_novalid", 64'(out_valid), 64'd0);
      end
      mode = 2'd2;
      for (int k = 1; k <= 4; k++) begin
         tick();
         @(negedge clk);
         check($sformatf("t4_restart_%0d", k), 64'(out_valid), 64'(k == 4));
      end

      // 5: free-run into a stalled consumer
      mode = 2'd0;
      tick();
      mode = 2'd1; out_ready = 1'b0; expq.push_back(W_D);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 5) begin
            @(negedge clk);
            check("t5_frozen", value, W_D);
            check("t5_drops_mid", 64'(drops), 64'd4);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t5_drops", 64'(drops), 64'd9);
      check("t5_valid", 64'(out_valid), 64'd1);
      tick();
      mon_en = 1'b0;
      @(negedge clk);
      check("t5_recapture_valid", 64'(out_valid), 64'd1);
      check("t5_drops_kept", 64'(drops), 64'd9);
      tick(); tick(); tick();
      @(negedge clk);
      check("t5_drops_stable", 64'(drops), 64'd9);

      // 6a: ld_seed beats a simultaneous step
      tick();
      ld_seed = 1'b1; step = 1'b1; mode = 2'd3; seed = 32'd1; out_ready = 1'b0;
      tick();
      @(negedge clk);
      check("t6_ld_valid", 64'(out_valid), 64'd0);
      check("t6_ld_drops", 64'(drops), 64'd0);
      ld_seed = 1'b0; out_ready = 1'b1; mon_en = 1'b1;
      expq.push_back(W_S1A);
      tick();
      step = 1'b0;
      tick();
      tick();

      // 6b: async reset in the middle of a tick count with a word pending
      mode = 2'd1; out_ready = 1'b0;
      tick(); tick(); tick();
      @(negedge clk);
      check("t6_pre_drops", 64'(drops), 64'd2);
      mode = 2'd2;
      tick(); tick();
      RESET_SIM = 1'b1;
      #1;
      check("t6_rst_value", value, 64'd0);
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_drops", 64'(drops), 64'd0);
      tick();
      RESET_SIM = 1'b0; mode = 2'd3; step = 1'b1; out_ready = 1'b1;
      expq.push_back(W_RST);
      tick();
      step = 1'b0;
      tick();
      tick();

      check("sb_drained", 64'(expq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
